// File: rtl/stopwatch_pkg.sv
// Shared constants for the stopwatch controller: FSM encoding, default timing
// parameters and the BCD increment used by the counter chain.
package stopwatch_pkg;

  localparam int DEF_TICKS_PER_UNIT = 8;
  localparam int DEF_DEB_TICKS      = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;

  // Returns {wrap, next} for the ss.hh digit vector {st, so, ht, ho}.
  function automatic logic [16:0] bcd_inc(input logic [15:0] v);
    logic [3:0] ho, ht, so, st;
    logic       wrap;
    ho   = v[3:0];
    ht   = v[7:4];
    so   = v[11:8];
    st   = v[15:12];
    wrap = 1'b0;
    if (ho != 4'd9) ho = ho + 4'd1;
    else begin
      ho = 4'd0;
      if (ht != 4'd9) ht = ht + 4'd1;
      else begin
        ht = 4'd0;
        if (so != 4'd9) so = so + 4'd1;
        else begin
          so = 4'd0;
          if (st != 4'd5) st = st + 4'd1;
          else begin
            st   = 4'd0;
            wrap = 1'b1;
          end
        end
      end
    end
    return {wrap, st, so, ht, ho};
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton conditioner: 2-flop synchroniser, tick-sampled debounce and a
// one-clk press pulse on each accepted 0->1 level change.
module btn_debounce #(
  parameter int DEB_TICKS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_tick,
  input  logic i_raw,
  output logic o_level,
  output logic o_press
);

  localparam int CW = (DEB_TICKS > 1) ? $clog2(DEB_TICKS + 1) : 1;

  logic          r_s1, r_s2, r_level, r_press;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_level <= 1'b0;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_s1    <= i_raw;
      r_s2    <= r_s1;
      r_press <= 1'b0;
      if (i_tick) begin
        // Any sample agreeing with the current level restarts the run.
        if (r_s2 == r_level) r_cnt <= '0;
        else if (r_cnt == CW'(DEB_TICKS - 1)) begin
          r_cnt   <= '0;
          r_level <= r_s2;
          r_press <= r_s2;
        end else r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_level = r_level;
  assign o_press = r_press;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: slow-clock tick extraction, start/pause/clear FSM,
// ss.hh BCD counter with sticky wrap flag and a 4-digit display scan mux.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int TICKS_PER_UNIT = DEF_TICKS_PER_UNIT,
  parameter int DEB_TICKS      = DEF_DEB_TICKS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        slow_clk,
  input  logic        btn_start,
  input  logic        btn_clr,
  output logic [15:0] bcd,
  output logic        running,
  output logic        ovf,
  output logic [3:0]  an,
  output logic [3:0]  scan_bcd
);

  localparam int PW = (TICKS_PER_UNIT > 1) ? $clog2(TICKS_PER_UNIT) : 1;

  logic          r_sc_s1, r_sc_s2, r_sc_d3, r_tick;
  logic [1:0]    r_state;
  logic [PW-1:0] r_presc;
  logic [15:0]   r_bcd;
  logic          r_ovf;
  logic [3:0]    r_an, r_scan;

  logic          w_start_press, w_clr_press;
  logic [1:0]    w_state_nxt;
  logic [PW-1:0] w_presc_nxt;
  logic [15:0]   w_bcd_nxt, w_bcd_inc;
  logic          w_ovf_nxt, w_wrap;
  logic [3:0]    w_an_nxt, w_scan_nxt;

  // slow_clk is data: synchronise, then a registered rising-edge detect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sc_s1 <= 1'b0;
      r_sc_s2 <= 1'b0;
      r_sc_d3 <= 1'b0;
      r_tick  <= 1'b0;
    end else begin
      r_sc_s1 <= slow_clk;
      r_sc_s2 <= r_sc_s1;
      r_sc_d3 <= r_sc_s2;
      r_tick  <= r_sc_s2 & ~r_sc_d3;
    end
  end

  btn_debounce #(.DEB_TICKS(DEB_TICKS)) u_deb_start (
    .clk(clk), .rst(rst), .i_tick(r_tick), .i_raw(btn_start),
    .o_level(), .o_press(w_start_press)
  );

  btn_debounce #(.DEB_TICKS(DEB_TICKS)) u_deb_clr (
    .clk(clk), .rst(rst), .i_tick(r_tick), .i_raw(btn_clr),
    .o_level(), .o_press(w_clr_press)
  );

  assign {w_wrap, w_bcd_inc} = bcd_inc(r_bcd);

  // Counting looks at r_state, so a tick coinciding with a press uses the old state.
  always_comb begin
    w_state_nxt = r_state;
    w_presc_nxt = r_presc;
    w_bcd_nxt   = r_bcd;
    w_ovf_nxt   = r_ovf;
    if (r_tick && r_state == ST_RUN) begin
      if (r_presc == PW'(TICKS_PER_UNIT - 1)) begin
        w_presc_nxt = '0;
        w_bcd_nxt   = w_bcd_inc;
        w_ovf_nxt   = r_ovf | w_wrap;
      end else w_presc_nxt = r_presc + 1'b1;
    end
    if (w_start_press) begin
      case (r_state)
        ST_IDLE:  w_state_nxt = ST_RUN;
        ST_RUN:   w_state_nxt = ST_PAUSE;
        ST_PAUSE: w_state_nxt = ST_RUN;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
    if (w_clr_press) begin
      w_state_nxt = ST_IDLE;
      w_presc_nxt = '0;
      w_bcd_nxt   = '0;
      w_ovf_nxt   = 1'b0;
    end
  end

  assign w_an_nxt = r_tick ? {r_an[2:0], r_an[3]} : r_an;

  // Digit chosen from next-state values so scan_bcd always matches bcd under an.
  always_comb begin
    w_scan_nxt = w_bcd_nxt[15:12];
    case (w_an_nxt)
      4'b1110: w_scan_nxt = w_bcd_nxt[3:0];
      4'b1101: w_scan_nxt = w_bcd_nxt[7:4];
      4'b1011: w_scan_nxt = w_bcd_nxt[11:8];
      default: w_scan_nxt = w_bcd_nxt[15:12];
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_presc <= '0;
      r_bcd   <= '0;
      r_ovf   <= 1'b0;
      r_an    <= 4'b1110;
      r_scan  <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_presc <= w_presc_nxt;
      r_bcd   <= w_bcd_nxt;
      r_ovf   <= w_ovf_nxt;
      r_an    <= w_an_nxt;
      r_scan  <= w_scan_nxt;
    end
  end

  assign bcd      = r_bcd;
  assign running  = (r_state == ST_RUN);
  assign ovf      = r_ovf;
  assign an       = r_an;
  assign scan_bcd = r_scan;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with TICKS_PER_UNIT=2, DEB_TICKS=2.
module tb_stopwatch_ctrl;

  logic        clk = 1'b0, rst = 1'b1, slow_clk = 1'b0;
  logic        btn_start = 1'b0, btn_clr = 1'b0;
  logic [15:0] bcd;
  logic        running, ovf;
  logic [3:0]  an, scan_bcd;

  int errors = 0;
  int checks = 0;
  int sc_half = 4;

  stopwatch_ctrl #(.TICKS_PER_UNIT(2), .DEB_TICKS(2)) dut (
    .clk(clk), .rst(rst), .slow_clk(slow_clk), .btn_start(btn_start),
    .btn_clr(btn_clr), .bcd(bcd), .running(running), .ovf(ovf),
    .an(an), .scan_bcd(scan_bcd)
  );

  always #5 clk = ~clk;

  initial forever begin
    repeat (sc_half) @(negedge clk);
    slow_clk = ~slow_clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] digit_of(input logic [15:0] v, input logic [3:0] a);
    case (a)
      4'b1110: return v[3:0];
      4'b1101: return v[7:4];
      4'b1011: return v[11:8];
      default: return v[15:12];
    endcase
  endfunction

  // Wait n slow_clk rises, then long enough for the tick and any press to land.
  task automatic wait_ticks(input int n);
    repeat (n) @(posedge slow_clk);
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic step(output int cyc_inc);
    @(posedge clk);
    #1;
    cyc_inc = 1;
  endtask

  typedef struct {
    logic        st;
    logic        cl;
    int          n;
    logic        run;
    logic [15:0] bcd;
  } vec_t;

  vec_t vecs[14];

  initial begin
    int cyc, inc, tcount;
    logic [3:0] exp_an[3];

    vecs[0]  = '{1'b1, 1'b0,   2, 1'b1, 16'h0000};
    vecs[1]  = '{1'b0, 1'b0, 200, 1'b1, 16'h0100};
    vecs[2]  = '{1'b1, 1'b0,   2, 1'b0, 16'h0101};
    vecs[3]  = '{1'b0, 1'b0,  50, 1'b0, 16'h0101};
    vecs[4]  = '{1'b1, 1'b0,   2, 1'b1, 16'h0101};
    vecs[5]  = '{1'b0, 1'b0,   3, 1'b1, 16'h0102};
    vecs[6]  = '{1'b0, 1'b1,   2, 1'b0, 16'h0000};
    vecs[7]  = '{1'b0, 1'b0,   2, 1'b0, 16'h0000};
    vecs[8]  = '{1'b1, 1'b0,   1, 1'b0, 16'h0000};
    vecs[9]  = '{1'b0, 1'b0,   3, 1'b0, 16'h0000};
    vecs[10] = '{1'b1, 1'b0,   2, 1'b1, 16'h0000};
    vecs[11] = '{1'b0, 1'b0,   4, 1'b1, 16'h0002};
    vecs[12] = '{1'b1, 1'b1,   2, 1'b0, 16'h0000};
    vecs[13] = '{1'b0, 1'b0,   2, 1'b0, 16'h0000};
    exp_an[0] = 4'b1011;
    exp_an[1] = 4'b0111;
    exp_an[2] = 4'b1110;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_bcd", bcd, 16'h0000);
    check("rst_running", running, 1'b0);
    check("rst_ovf", ovf, 1'b0);
    check("rst_an", an, 4'b1110);
    check("rst_scan", scan_bcd, 4'h0);
    @(negedge clk);
    rst = 1'b0;

    // Tick latency and width, scan rotation
    @(posedge slow_clk);
    @(posedge clk); #1; check("tick_e1", dut.r_tick, 1'b0);
    @(posedge clk); #1; check("tick_e2", dut.r_tick, 1'b0);
    @(posedge clk); #1; check("tick_e3", dut.r_tick, 1'b1);
    check("an_before_tick", an, 4'b1110);
    @(posedge clk); #1; check("tick_e4", dut.r_tick, 1'b0);
    check("an_step1", an, 4'b1101);
    for (int i = 0; i < 3; i++) begin
      @(posedge slow_clk);
      repeat (4) @(posedge clk);
      #1;
      check($sformatf("an_step%0d", i + 2), an, exp_an[i]);
    end
    tcount = 0;
    for (int i = 0; i < 64; i++) begin
      @(posedge clk); #1;
      if (dut.r_tick) tcount++;
    end
    check("tick_count_64clk", tcount, 8);

    // Table-driven button sequences
    for (int i = 0; i < 14; i++) begin
      btn_start = vecs[i].st;
      btn_clr   = vecs[i].cl;
      wait_ticks(vecs[i].n);
      check($sformatf("v%0d_running", i), running, vecs[i].run);
      check($sformatf("v%0d_bcd", i), bcd, vecs[i].bcd);
      check($sformatf("v%0d_ovf", i), ovf, 1'b0);
      check($sformatf("v%0d_scan", i), scan_bcd, digit_of(vecs[i].bcd, an));
      check($sformatf("v%0d_an_onehot", i), $countones(~an), 1);
    end

    // Run up to 59.99 with a fast slow_clk, then wrap
    sc_half = 1;
    repeat (20) @(posedge clk);
    btn_start = 1'b1;
    cyc = 0;
    while (!running && cyc < 200) begin step(inc); cyc += inc; end
    check("ovf_start", running, 1'b1);
    btn_start = 1'b0;
    cyc = 0;
    while (bcd != 16'h5999 && cyc < 30000) begin step(inc); cyc += inc; end
    check("reach_5999", bcd, 16'h5999);
    check("ovf_before_wrap", ovf, 1'b0);
    cyc = 0;
    while (bcd == 16'h5999 && cyc < 20) begin step(inc); cyc += inc; end
    check("wrap_cycles", cyc, 4);
    check("wrap_bcd", bcd, 16'h0000);
    check("wrap_ovf", ovf, 1'b1);
    repeat (40) @(posedge clk);
    #1;
    check("post_wrap_bcd", bcd, 16'h0010);
    check("ovf_sticky", ovf, 1'b1);
    btn_clr = 1'b1;
    cyc = 0;
    while (running && cyc < 200) begin step(inc); cyc += inc; end
    check("clr_running", running, 1'b0);
    check("clr_bcd", bcd, 16'h0000);
    check("clr_ovf", ovf, 1'b0);
    btn_clr = 1'b0;
    repeat (20) @(posedge clk);

    // Asynchronous reset mid-run
    btn_start = 1'b1;
    cyc = 0;
    while (!running && cyc < 200) begin step(inc); cyc += inc; end
    btn_start = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check("pre_rst_running", running, 1'b1);
    check("pre_rst_bcd_nonzero", (bcd != 16'h0000), 1'b1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst_bcd", bcd, 16'h0000);
    check("arst_running", running, 1'b0);
    check("arst_ovf", ovf, 1'b0);
    check("arst_an", an, 4'b1110);
    check("arst_scan", scan_bcd, 4'h0);

    // Button held through reset release gives exactly one press
    btn_start = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    while (!running && cyc < 200) begin step(inc); cyc += inc; end
    check("held_rst_press", running, 1'b1);
    check("held_rst_delay", (cyc >= 4), 1'b1);
    repeat (60) @(posedge clk);
    #1;
    check("held_single_press", running, 1'b1);
    btn_start = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 SHALL have parameter TICKS_PER_UNIT, default 8: slow-clock ticks per 1/100-second unit.
REQ-002 SHALL have parameter DEB_TICKS, default 4: consecutive equal tick samples needed to accept a button level.
REQ-003 SHALL have port clk  in  1  system clock; all state is clocked on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port slow_clk  in  1  divided square wave from the clock divider; sampled as data, never used as a clock.
REQ-006 SHALL have port btn_start  in  1  raw start/pause pushbutton, active-high, asynchronous.
REQ-007 SHALL have port btn_clr  in  1  raw clear pushbutton, active-high, asynchronous.
REQ-008 SHALL have port bcd  out  16  digits {sec_tens, sec_ones, hun_tens, hun_ones}, 4 bits each.
REQ-009 SHALL have port running  out  1  high while in RUN.
REQ-010 SHALL have port ovf  out  1  sticky wrap flag.
REQ-011 SHALL have port an  out  4  one-hot, active-low digit select for display scanning.
REQ-012 SHALL have port scan_bcd  out  4  BCD value of the digit selected by an.

Function
REQ-013 SHALL synchronise slow_clk through two flops and SHALL raise an internal tick for exactly one clk cycle on each synchronised 0->1 edge.
REQ-014 Tick SHALL assert on the 3rd clk edge after slow_clk rises; no tick on the falling edge.
REQ-015 Each button SHALL be 2-flop synchronised, then sampled only on tick; the debounced level SHALL change only after DEB_TICKS consecutive equal samples differing from it.
REQ-016 Each debounced 0->1 transition SHALL produce a one-clk press pulse; releases and bounces shorter than DEB_TICKS ticks SHALL produce none.
REQ-017 FSM states: IDLE, RUN, PAUSE; reset state IDLE.
REQ-018 start press: IDLE->RUN, RUN->PAUSE, PAUSE->RUN.
REQ-019 clr press: any state->IDLE; clears digits, prescaler and ovf on the same edge.
REQ-020 clr and start press in the same cycle: clr wins, start is discarded.
REQ-021 Prescaler (width clog2(TICKS_PER_UNIT)) SHALL advance on tick only in RUN, hold in PAUSE, and stay 0 in IDLE.
REQ-022 On tick with prescaler = TICKS_PER_UNIT-1: prescaler->0 and hundredths increment by 1.
REQ-023 Hundredths SHALL count 00..99 in BCD; 99->00 SHALL carry into seconds.
REQ-024 Seconds SHALL count 00..59 in BCD.
REQ-025 59.99->00.00 SHALL set ovf; ovf stays 1 until clr or rst, and counting continues.
REQ-026 bcd SHALL be registered and SHALL update on the clk edge of the increment; running SHALL equal (state==RUN).
REQ-027 Scan index SHALL advance 0->1->2->3->0 on every tick in all states.
REQ-028 Index k SHALL drive an[k]=0 and all other an bits 1; scan_bcd = bcd[4k+3:4k], registered with an.
REQ-029 A tick landing in the same cycle as a state change SHALL be processed with the pre-change state.

Reset
REQ-030 rst SHALL asynchronously force: state IDLE, bcd 0x0000, running 0, ovf 0, an 4'b1110, scan_bcd 0, prescaler 0, sync and debounce flops 0, debounced levels 0.
REQ-031 Releasing rst with a button held SHALL yield exactly one press once DEB_TICKS ticks elapse.

Structure
REQ-032 Shared package stopwatch_pkg SHALL hold the FSM state encoding and the default TICKS_PER_UNIT and DEB_TICKS values.
REQ-033 SHALL instantiate sub-module btn_debounce twice, one per button; it takes tick and raw input and outputs level and press pulse.
REQ-034 Tick generator, FSM, BCD counter chain and scan mux SHALL live in stopwatch_ctrl.

Verification (TICKS_PER_UNIT=2, DEB_TICKS=2, slow_clk period 8 clk)
REQ-035 Reset then free-run slow_clk -> each tick 1 clk wide, 3 cycles after each slow_clk rise; an cycles 1110,1101,1011,0111 one step per tick.
REQ-036 start held 2 ticks -> running=1; after 200 ticks bcd=0x0100; second start press -> running=0 and bcd frozen over 50 ticks.
REQ-037 start pulse lasting 1 tick -> no press, state stays IDLE.
REQ-038 Preload via run to bcd=0x5999 with prescaler 1, next tick -> bcd=0x0000, ovf=1; clr press -> ovf=0, IDLE.
REQ-039 start and clr debounced presses in the same cycle while in RUN -> IDLE, bcd=0x0000.
REQ-040 rst asserted mid-RUN between clk edges -> outputs take REQ-030 values immediately, without waiting for a clk edge.
